// File: rtl/waveshaper_gen2.sv
// Registered waveshaper: turns the seq-div quotient and oscillator count into one scaled
// sample per clock. Shape changes are deferred to an oscillator period wrap.
//
// mode_q | meaning
// -------+------------------------------------------------------------
// OFF    | raw shape is 0; a new non-off request is taken on the next edge
// SQUARE | MAX while count is past half the period, else 0
// SAW    | quotient passed straight through
// TRI    | doubled quotient rising, mirrored falling, clamped to [0,MAX]
// PULSE  | MAX while quotient is below duty, else 0
// NOISE  | top bits of the Galois LFSR, advanced once per enabled wrap
module waveshaper_gen2 #(
  parameter int unsigned SW        = 8,
  parameter int unsigned CW        = 19,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [SW-1:0] Q,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] divisor,
  input  logic [SW-1:0] duty,
  input  logic [SW-1:0] volume,
  output logic [SW-1:0] sample,
  output logic          period_st
);

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_SQUARE = 3'd1,
    MODE_SAW    = 3'd2,
    MODE_TRI    = 3'd3,
    MODE_PULSE  = 3'd4,
    MODE_NOISE  = 3'd5
  } mode_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  mode_e          mode_q, mode_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [SW-1:0]  sample_q, sample_d;
  logic           period_st_q, period_st_d;

  logic           wrap;
  logic [CW-1:0]  half;
  logic [SW-1:0]  max_c;
  logic [SW+1:0]  q2;
  logic [SW+1:0]  two_max;
  logic [SW+1:0]  fall_full;
  logic [SW:0]    rise;
  logic [SW:0]    fall;
  logic [SW:0]    raw;
  logic [SW:0]    vol_p1;
  logic [2*SW+1:0] prod;
  logic           unused_prod;

  // Wrap detection and mode/LFSR sequencing
  always_comb begin
    count_d     = count;
    wrap        = (count < count_q);
    period_st_d = wrap & en;

    mode_d = mode_q;
    if (mode == 3'd0 || mode >= 3'd6) begin
      mode_d = MODE_OFF;
    end else if (mode_q == MODE_OFF) begin
      mode_d = mode_e'(mode);
    end else if (wrap) begin
      mode_d = mode_e'(mode);
    end

    lfsr_d = lfsr_q;
    if (wrap && en) begin
      if (lfsr_q[0]) begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ LFSR_MASK;
      end else begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
      end
    end
  end

  // Shape generation uses the mode registered before this edge
  always_comb begin
    max_c   = '1;
    half    = divisor >> 1;
    q2      = {1'b0, Q, 1'b0};
    two_max = {1'b0, max_c, 1'b0};

    rise = (q2 > {2'b00, max_c}) ? {1'b0, max_c} : q2[SW:0];

    fall_full = '0;
    if (q2 < two_max) begin
      fall_full = two_max - q2;
    end
    fall = (fall_full > {2'b00, max_c}) ? {1'b0, max_c} : fall_full[SW:0];

    raw = '0;
    unique case (mode_q)
      MODE_SQUARE: raw = (count > half) ? {1'b0, max_c} : '0;
      MODE_SAW:    raw = {1'b0, Q};
      MODE_TRI:    raw = (count < half) ? rise : fall;
      MODE_PULSE:  raw = (Q < duty) ? {1'b0, max_c} : '0;
      MODE_NOISE:  raw = {1'b0, lfsr_q[15 -: SW]};
      default:     raw = '0;
    endcase
  end

  // Volume: (raw * (volume + 1)) >> SW, exact pass-through at full volume
  always_comb begin
    vol_p1   = {1'b0, volume} + {{SW{1'b0}}, 1'b1};
    prod     = {{(SW+1){1'b0}}, raw} * {{(SW+1){1'b0}}, vol_p1};
    sample_d = en ? prod[2*SW-1:SW] : '0;
  end

  assign unused_prod = ^{prod[2*SW+1:2*SW], prod[SW-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      count_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      sample_q    <= '0;
      period_st_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      count_q     <= count_d;
      lfsr_q      <= lfsr_d;
      sample_q    <= sample_d;
      period_st_q <= period_st_d;
    end
  end

  assign sample    = sample_q;
  assign period_st = period_st_q;

endmodule

// File: tb/tb_waveshaper_gen2.sv
// Scoreboard bench for waveshaper_gen2 (SW=8, CW=19): directed vectors push expected
// sample/period_st; a monitor pops and compares one entry per clock.
module tb_waveshaper_gen2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [7:0]  Q;
  logic [18:0] count;
  logic [18:0] divisor;
  logic [7:0]  duty;
  logic [7:0]  volume;
  logic [7:0]  sample;
  logic        period_st;

  waveshaper_gen2 #(.SW(8), .CW(19), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .Q(Q), .count(count),
    .divisor(divisor), .duty(duty), .volume(volume),
    .sample(sample), .period_st(period_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       p;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;
  bit   done;

  // stimulus-side settings
  bit          r_v;
  bit          en_v;
  logic [18:0] div_v;
  logic [7:0]  duty_v;
  logic [7:0]  vol_v;

  // reference model state
  int          m_mode;
  int          m_count;
  logic [15:0] m_lfsr;

  task automatic cyc(input int md, input int q, input int c, input int hand, input string nm);
    exp_t e;
    int   raw, half, s, rise, fall;
    bit   wrap, lsb;
    @(negedge clk);
    rst = r_v; en = en_v; mode = md[2:0]; Q = q[7:0]; count = c[18:0];
    divisor = div_v; duty = duty_v; volume = vol_v;
    if (r_v) begin
      m_mode = 0; m_count = 0; m_lfsr = 16'hACE1;
      e.s = 8'd0; e.p = 1'b0;
    end else begin
      wrap = (c < m_count);
      half = int'(div_v) / 2;
      rise = (2 * q > 255) ? 255 : 2 * q;
      fall = 510 - 2 * q;
      if (fall < 0) fall = 0;
      if (fall > 255) fall = 255;
      case (m_mode)
        1: raw = (c > half) ? 255 : 0;
        2: raw = q;
        3: raw = (c < half) ? rise : fall;
        4: raw = (q < int'(duty_v)) ? 255 : 0;
        5: raw = int'(m_lfsr[15:8]);
        default: raw = 0;
      endcase
      s = en_v ? (raw * (int'(vol_v) + 1)) / 256 : 0;
      e.s = s[7:0];
      e.p = wrap && en_v;
      if (md == 0 || md >= 6) m_mode = 0;
      else if (m_mode == 0 || wrap) m_mode = md;
      if (wrap && en_v) begin
        lsb = m_lfsr[0];
        m_lfsr = m_lfsr >> 1;
        if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
      end
      m_count = c;
    end
    if (hand >= 0) e.s = hand[7:0];
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compares one scoreboard entry per clock, then prints the summary
  initial begin
    exp_t e;
    tests = 0; fails = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (sample !== e.s) begin
          fails++;
          $display("FAIL %s sample: got %0d expected %0d at %0t", e.nm, sample, e.s, $time);
        end
        tests++;
        if (period_st !== e.p) begin
          fails++;
          $display("FAIL %s period_st: got %0b expected %0b at %0t", e.nm, period_st, e.p, $time);
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    done = 1'b0;
    rst = 1'b1; en = 1'b0; mode = 3'd0; Q = '0; count = '0;
    divisor = '0; duty = '0; volume = '0;
    r_v = 1'b1; en_v = 1'b1; div_v = 19'd100; duty_v = 8'd0; vol_v = 8'd255;
    m_mode = 0; m_count = 0; m_lfsr = 16'hACE1;

    // reset with random inputs
    for (int i = 0; i < 4; i++)
      cyc($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 500000), -1, "reset");
    r_v = 1'b0;
    cyc(5, 0, 0, 0, "rst_release");
    cyc(5, 0, 1, 172, "noise_first");
    cyc(0, 0, 2, -1, "to_off");

    // square sweep, two periods
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 100; c++)
        cyc(1, 0, c, (c > 50) ? 255 : 0, "square");

    // triangle
    cyc(3, 0, 0, 0, "tri_wrap");
    cyc(3, 0, 10, 0, "tri_q0");
    cyc(3, 64, 11, 128, "tri_q64");
    cyc(3, 127, 12, 254, "tri_q127");
    cyc(3, 128, 60, 254, "tri_q128");
    cyc(3, 255, 61, 0, "tri_q255");
    cyc(3, 200, 62, 110, "tri_q200");

    // deferred mode switch saw -> square, then off
    cyc(0, 0, 70, -1, "to_off2");
    cyc(2, 80, 71, 0, "saw_arm");
    for (int c = 72; c < 90; c++) cyc(2, c, c, c, "saw");
    for (int c = 90; c < 100; c++) cyc(1, c, c, c, "saw_pending");
    cyc(1, 60, 60, 60, "saw_wrap");
    cyc(1, 61, 61, 255, "square_new");
    cyc(1, 62, 62, 255, "square_new2");
    cyc(0, 63, 63, 255, "off_pending");
    cyc(0, 64, 64, 0, "off");

    // pulse and volume
    duty_v = 8'd64;
    cyc(4, 63, 65, 0, "pulse_arm");
    cyc(4, 63, 66, 255, "pulse_below");
    cyc(4, 64, 67, 0, "pulse_at_duty");
    vol_v = 8'd127;
    cyc(4, 0, 68, 127, "vol127");
    vol_v = 8'd255; duty_v = 8'd0;
    cyc(4, 0, 69, 0, "duty0");
    duty_v = 8'd255;
    cyc(4, 254, 70, 255, "duty_max_254");
    cyc(4, 255, 71, 0, "duty_max_255");
    vol_v = 8'd0;
    for (int m = 1; m <= 5; m++) begin
      cyc(0, 10, 72 + 3 * (m - 1), 0, "vol0_off");
      cyc(m, 10, 73 + 3 * (m - 1), 0, "vol0_arm");
      cyc(m, 10, 74 + 3 * (m - 1), 0, "vol0");
    end

    // divisor 0
    vol_v = 8'd255; div_v = 19'd0;
    cyc(0, 0, 87, -1, "div0_off");
    cyc(1, 0, 88, 0, "div0_arm");
    cyc(1, 0, 89, 255, "div0_sq");
    cyc(1, 0, 0, 0, "div0_sq0");
    cyc(1, 0, 1, 255, "div0_sq1");
    div_v = 19'd100;

    // noise: 20 wraps enabled, 5 disabled, 2 re-enabled
    cyc(0, 0, 2, -1, "noise_off");
    cyc(5, 0, 3, -1, "noise_arm");
    for (int w = 0; w < 20; w++)
      for (int c = 0; c < 4; c++) cyc(5, 0, c, -1, "noise");
    en_v = 1'b0;
    for (int w = 0; w < 5; w++)
      for (int c = 0; c < 4; c++) cyc(5, 0, c, 0, "noise_en0");
    en_v = 1'b1;
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 4; c++) cyc(5, 0, c, -1, "noise_resume");

    // reset mid-period
    r_v = 1'b1;
    cyc(5, 7, 50, 0, "rst_mid");
    r_v = 1'b0;
    cyc(5, 0, 0, 0, "rst_mid_release");
    cyc(5, 0, 1, 172, "noise_after_rst");

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
